// File: rtl/teclado_emulador_if.sv
// rtl/teclado_emulador_if.sv - keypad emulator bus: row drive, key request, column sense, status
//  FILAS     row drive from the scanner (one-hot, active-high)
//  start     one-cycle key-press request
//  key_code  key to press, 0x0-0xF
//  COLUMNAS  column sense back to the scanner (active-high)
//  busy      press/release sequence in progress
//  done      one-cycle pulse at the end of the sequence
//  overrun   one-cycle pulse when a request is dropped
//  slave  : emulator side
//  master : scanner / requester side
interface teclado_emulador_if;
  logic [3:0] FILAS;
  logic       start;
  logic [3:0] key_code;
  logic [3:0] COLUMNAS;
  logic       busy;
  logic       done;
  logic       overrun;

  modport slave (
    input  FILAS, start, key_code,
    output COLUMNAS, busy, done, overrun
  );

  modport master (
    output FILAS, start, key_code,
    input  COLUMNAS, busy, done, overrun
  );
endinterface

// File: rtl/teclado_emulador.sv
// rtl/teclado_emulador.sv - 4x4 matrix keypad emulator with contact bounce and hold timing
//  clk  system clock
//  rst  asynchronous reset, active-low
//  bus  teclado_emulador_if.slave (FILAS, start, key_code in; COLUMNAS, busy, done, overrun out)
module teclado_emulador #(
  parameter int HOLD_CYCLES    = 2_500_000,
  parameter int GAP_CYCLES     = 2_500_000,
  parameter int BOUNCE_TOGGLES = 4,
  parameter int BOUNCE_PERIOD  = 50_000
) (
  input  logic                  clk,
  input  logic                  rst,
  teclado_emulador_if.slave     bus
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_HG > BOUNCE_PERIOD) ? MAX_HG : BOUNCE_PERIOD;
  localparam int CW = $clog2(MAX_ALL) + 1;
  localparam int TW = $clog2(BOUNCE_TOGGLES + 1) + 1;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] BOUNCE_IN  = 3'd1;
  localparam logic [2:0] HOLD       = 3'd2;
  localparam logic [2:0] BOUNCE_OUT = 3'd3;
  localparam logic [2:0] GAP        = 3'd4;

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(BOUNCE_PERIOD - 1);
  localparam logic [TW-1:0] TOG_LAST    = TW'(BOUNCE_TOGGLES - 1);
  localparam bit            HAS_BOUNCE  = (BOUNCE_TOGGLES > 0);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tog;
  logic          contact;
  logic [3:0]    row_tgt;
  logic [3:0]    col_tgt;
  logic [3:0]    filas_m;
  logic [3:0]    filas_s;
  logic [3:0]    columnas_q;
  logic          busy_q;
  logic          overrun_q;

  // Returns {row_onehot, col_onehot} for a key code.
  function automatic logic [7:0] decode_key(input logic [3:0] k);
    case (k)
      4'h1: decode_key = {4'b0001, 4'b0001};
      4'h2: decode_key = {4'b0001, 4'b0010};
      4'h3: decode_key = {4'b0001, 4'b0100};
      4'hA: decode_key = {4'b0001, 4'b1000};
      4'h4: decode_key = {4'b0010, 4'b0001};
      4'h5: decode_key = {4'b0010, 4'b0010};
      4'h6: decode_key = {4'b0010, 4'b0100};
      4'hB: decode_key = {4'b0010, 4'b1000};
      4'h7: decode_key = {4'b0100, 4'b0001};
      4'h8: decode_key = {4'b0100, 4'b0010};
      4'h9: decode_key = {4'b0100, 4'b0100};
      4'hC: decode_key = {4'b0100, 4'b1000};
      4'hE: decode_key = {4'b1000, 4'b0001};
      4'h0: decode_key = {4'b1000, 4'b0010};
      4'hF: decode_key = {4'b1000, 4'b0100};
      default: decode_key = {4'b1000, 4'b1000}; // 4'hD
    endcase
  endfunction

  // Row drive is asynchronous to our clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filas_m <= 4'b0000;
      filas_s <= 4'b0000;
    end else begin
      filas_m <= bus.FILAS;
      filas_s <= filas_m;
    end
  end

  // row_tgt is one-hot, so an idle or multi-row drive never matches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      columnas_q <= 4'b0000;
    end else begin
      columnas_q <= (contact && (filas_s == row_tgt)) ? col_tgt : 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tog       <= '0;
      contact   <= 1'b0;
      row_tgt   <= 4'b0000;
      col_tgt   <= 4'b0000;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= bus.start && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            {row_tgt, col_tgt} <= decode_key(bus.key_code);
            cnt     <= '0;
            tog     <= '0;
            contact <= 1'b1;
            busy_q  <= 1'b1;
            state   <= HAS_BOUNCE ? BOUNCE_IN : HOLD;
          end
        end
        BOUNCE_IN, BOUNCE_OUT: begin
          if (cnt == PERIOD_LAST) begin
            cnt     <= '0;
            contact <= ~contact;
            // An even toggle count leaves contact at its phase-entry level.
            if (tog == TOG_LAST) begin
              tog   <= '0;
              state <= (state == BOUNCE_IN) ? HOLD : GAP;
            end else begin
              tog <= tog + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt     <= '0;
            contact <= 1'b0;
            state   <= HAS_BOUNCE ? BOUNCE_OUT : GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          contact <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // done is high during the last GAP cycle, while the FSM is still busy, so a
  // start in that same cycle is counted as an overrun.
  assign bus.done     = (state == GAP) && (cnt == GAP_LAST);
  assign bus.COLUMNAS = columnas_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_teclado_emulador.sv
// tb/tb_teclado_emulador.sv - scoreboard testbench for teclado_emulador
module tb_teclado_emulador;

  typedef struct {
    logic [3:0] val;
    int         cyc;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  ev_t  col_q[$];
  int   done_q[$];
  int   ovr_q[$];
  logic [3:0] prev_col;

  teclado_emulador_if bus_i ();

  teclado_emulador #(
    .HOLD_CYCLES(20),
    .GAP_CYCLES(10),
    .BOUNCE_TOGGLES(4),
    .BOUNCE_PERIOD(2)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every column change, done pulse and overrun pulse must match the
  // next queued expectation, value and cycle.
  initial prev_col = 4'b0000;
  always @(negedge clk) begin
    if (bus_i.COLUMNAS !== prev_col) begin
      if (col_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL col_unexpected: got %b at cyc %0d expected no change", bus_i.COLUMNAS, cyc);
      end else begin
        ev_t e;
        e = col_q.pop_front();
        chk("col_value", int'(bus_i.COLUMNAS), int'(e.val));
        chk("col_cycle", cyc, e.cyc);
      end
      prev_col = bus_i.COLUMNAS;
    end
    if (bus_i.done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: got 1 at cyc %0d expected 0", cyc);
      end else begin
        chk("done_cycle", cyc, done_q.pop_front());
      end
    end
    if (bus_i.overrun === 1'b1) begin
      if (ovr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL overrun_unexpected: got 1 at cyc %0d expected 0", cyc);
      end else begin
        chk("overrun_cycle", cyc, ovr_q.pop_front());
      end
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_col(input logic [3:0] v, input int c);
    ev_t e;
    e.val = v;
    e.cyc = c;
    col_q.push_back(e);
  endtask

  // Contact pattern relative to the start cycle c0 (HOLD=20, GAP=10, 4 toggles of 2 clk):
  // bounce-in c0+1..8, hold c0+9..28, bounce-out c0+29..36, gap c0+37..46; columns lag by 1.
  task automatic push_head(input int c0, input logic [3:0] col);
    push_col(col, c0 + 2);
    push_col(4'b0000, c0 + 4);
    push_col(col, c0 + 6);
    push_col(4'b0000, c0 + 8);
    push_col(col, c0 + 10);
  endtask

  task automatic push_tail(input int c0, input logic [3:0] col);
    push_col(4'b0000, c0 + 30);
    push_col(col, c0 + 32);
    push_col(4'b0000, c0 + 34);
    push_col(col, c0 + 36);
    push_col(4'b0000, c0 + 38);
    done_q.push_back(c0 + 46);
  endtask

  task automatic press(input logic [3:0] k, output int c0);
    c0 = cyc;
    bus_i.start    = 1'b1;
    bus_i.key_code = k;
    @(negedge clk);
    bus_i.start    = 1'b0;
    bus_i.key_code = 4'($urandom);
  endtask

  task automatic set_filas_idle(input logic [3:0] f);
    bus_i.FILAS = f;
    repeat (4) @(negedge clk);
  endtask

  int c0;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_i.FILAS = 4'b0000;
    bus_i.start = 1'b0;
    bus_i.key_code = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_columnas", int'(bus_i.COLUMNAS), 0);
    chk("reset_busy", int'(bus_i.busy), 0);
    chk("reset_done", int'(bus_i.done), 0);
    chk("reset_overrun", int'(bus_i.overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset in the middle of HOLD
    set_filas_idle(4'b0001);
    press(4'h2, c0);
    push_head(c0, 4'b0010);
    push_col(4'b0000, c0 + 16);
    at_cyc(c0 + 15);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_columnas", int'(bus_i.COLUMNAS), 0);
    chk("midreset_busy", int'(bus_i.busy), 0);
    at_cyc(c0 + 18);
    rst_n = 1'b1;
    at_cyc(c0 + 70);
    chk("after_reset_busy", int'(bus_i.busy), 0);

    // 2: key 5 with the wrong row driven, then the right row during HOLD
    set_filas_idle(4'b0001);
    press(4'h5, c0);
    @(negedge clk);
    chk("busy_after_start", int'(bus_i.busy), 1);
    at_cyc(c0 + 15);
    bus_i.FILAS = 4'b0010;
    push_col(4'b0010, c0 + 18);
    push_tail(c0, 4'b0010);
    at_cyc(c0 + 47);
    chk("busy_after_done", int'(bus_i.busy), 0);
    at_cyc(c0 + 52);

    // 3: key 0 on row 3, full bounce pattern
    set_filas_idle(4'b1000);
    press(4'h0, c0);
    push_head(c0, 4'b0010);
    push_tail(c0, 4'b0010);
    at_cyc(c0 + 52);

    // 4: invalid row drives during HOLD of key 1
    set_filas_idle(4'b0001);
    press(4'h1, c0);
    push_head(c0, 4'b0001);
    push_col(4'b0000, c0 + 17);
    push_col(4'b0001, c0 + 21);
    push_col(4'b0000, c0 + 25);
    push_col(4'b0001, c0 + 28);
    push_tail(c0, 4'b0001);
    at_cyc(c0 + 14);
    bus_i.FILAS = 4'b0011;
    at_cyc(c0 + 18);
    bus_i.FILAS = 4'b0001;
    at_cyc(c0 + 22);
    bus_i.FILAS = 4'b0000;
    at_cyc(c0 + 25);
    bus_i.FILAS = 4'b0001;
    at_cyc(c0 + 52);

    // 5: overrun during BOUNCE_IN and in the done cycle; first key completes
    set_filas_idle(4'b0001);
    press(4'h3, c0);
    push_head(c0, 4'b0100);
    push_tail(c0, 4'b0100);
    at_cyc(c0 + 3);
    ovr_q.push_back(c0 + 4);
    bus_i.start = 1'b1;
    bus_i.key_code = 4'hA;
    @(negedge clk);
    bus_i.start = 1'b0;
    at_cyc(c0 + 46);
    ovr_q.push_back(c0 + 47);
    bus_i.start = 1'b1;
    bus_i.key_code = 4'h7;
    @(negedge clk);
    bus_i.start = 1'b0;
    at_cyc(c0 + 50);
    chk("done_cycle_start_ignored", int'(bus_i.busy), 0);
    at_cyc(c0 + 52);

    // 6: rotating row scan with key D held
    set_filas_idle(4'b0001);
    press(4'hD, c0);
    push_col(4'b1000, c0 + 22);
    push_col(4'b0000, c0 + 27);
    done_q.push_back(c0 + 46);
    at_cyc(c0 + 9);
    bus_i.FILAS = 4'b0010;
    at_cyc(c0 + 14);
    bus_i.FILAS = 4'b0100;
    at_cyc(c0 + 19);
    bus_i.FILAS = 4'b1000;
    at_cyc(c0 + 24);
    bus_i.FILAS = 4'b0001;
    at_cyc(c0 + 60);

    chk("col_q_drained", col_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    chk("ovr_q_drained", ovr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
